load_counter_sched: RTL and testbench
=====================================

Name: load_counter_sched

Overview:
- Scheduler that shares one loadable up-counter (4-bit: load, load value, count output; counts up and wraps) between NUM_REQ requesters.
- Each requester asks for one interval: the counter is loaded with the requester's start value and runs until it reaches all-ones.
- The block arbitrates, drives the counter's load interface, watches its count, and pulses done back to the owner.
- Sits between the requesters and the counter instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- CNT_W, 4, counter width; must match the counter instance
- IDX_W, $clog2(NUM_REQ), width of owner index (derived)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_i  in  NUM_REQ  per-requester request level
- req_val_i  in  NUM_REQ*CNT_W  start values, flattened; requester k uses bits [k*CNT_W +: CNT_W]
- gnt_o  out  NUM_REQ  one-hot grant, one-cycle pulse
- done_o  out  NUM_REQ  one-hot completion, one-cycle pulse
- busy_o  out  1  high whenever state is not IDLE
- owner_o  out  IDX_W  index of the current owner; valid while busy_o is high
- cnt_load_o  out  1  drives the counter's load_i
- cnt_load_val_o  out  CNT_W  drives the counter's load_val_i
- cnt_count_i  in  CNT_W  counter's count_o

Behaviour:
- Reset (async, immediate): state=IDLE; gnt_o=0, done_o=0, busy_o=0, owner_o=0, cnt_load_o=0, cnt_load_val_o=0; RR pointer set so that requester 0 wins first.
- All outputs are registered.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If req_i is non-zero at edge T, the arbiter picks winner w.
  - At T+1: state=LOAD, gnt_o[w]=1 (1 cycle), owner_o=w, cnt_load_o=1, cnt_load_val_o=req_val_i[w] sampled at T.
  - If req_i is zero, stay in IDLE.
- LOAD: exactly one cycle, then RUN; cnt_load_o returns to 0.
- RUN:
  - The first RUN cycle sees cnt_count_i = loaded value.
  - When cnt_count_i == all-ones, go to DONE.
  - No timeout.
- DONE: done_o[owner]=1 for one cycle, then IDLE.
  - DONE always returns to IDLE; there is no direct DONE->LOAD, so there is one bubble between jobs.
- Latency: request seen at T with start value v gives gnt at T+1 and done at T+3+(2^CNT_W-1-v).
  - CNT_W=4, v=0: done at T+18.
  - v=0xF: done at T+3.
- Back-to-back grant period at v=all-ones: 4 cycles.
- req_i is a level signal. It may be withdrawn before grant (no effect). The requester must drop req_i in the gnt cycle, or a new request is recorded.
- req_i and req_val_i are ignored outside IDLE; changes to req_val_i after grant do not affect the running job.
- Counter wrap after all-ones is ignored; the scheduler only detects the first all-ones in RUN.
- Reset mid-job: job is dropped, no done_o, the counter is left free-running. After release, a pending request is granted normally from IDLE.
- Invariants: gnt_o and done_o are each zero or one-hot; they never assert in the same cycle.

Optional Feature:
- Macro LCS_ROUND_ROBIN_EN.
- Defined: round-robin arbitration.
  - Search starts at (last granted + 1) mod NUM_REQ.
  - The pointer updates on each grant.
- Undefined: fixed priority, lowest index wins.
  - A continuously requesting requester 0 starves the others.
  - No pointer register.

Test Plan:
- Reset: hold reset 3 cycles with req_i=0 -> all outputs 0. Assert reset asynchronously mid-cycle -> outputs clear before the next edge.
- Single job: req_i=0001, start value 0x3 seen at T -> gnt_o=0001 at T+1; cnt_load_o=1 with cnt_load_val_o=3 at T+1; done_o=0001 at T+15 only; busy_o high T+1..T+15.
- Edge value: requester 2, start value 0xF -> gnt at T+1, done_o=0100 at T+3. Start value 0x0 -> done at T+18.
- Simultaneous: req_i=0101 with values 0xC and 0xE, both held until granted -> requester 0 is granted first and done after 6 cycles; then requester 2 is granted after the IDLE bubble; done_o order 0001 then 0100.
- Fairness (macro defined): req_i=1111 held, all values 0xF -> gnt order 0,1,2,3,0 with a 4-cycle period. Same stimulus with the macro undefined -> gnt_o=0001 every time.
- Reset during RUN: req 1, value 0x0, assert reset 5 cycles after gnt -> no done_o. Release with req_i=0010 still high -> fresh grant to requester 1, full 17-cycle job.

Source files
------------

// File: rtl/load_counter_sched_if.sv
// Requester/counter-side signal bundle for load_counter_sched.
// slave = scheduler view, master = requesters plus counter view.
interface load_counter_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0]       req_i;
  logic [NUM_REQ*CNT_W-1:0] req_val_i;
  logic [NUM_REQ-1:0]       gnt_o;
  logic [NUM_REQ-1:0]       done_o;
  logic                     busy_o;
  logic [IDX_W-1:0]         owner_o;
  logic                     cnt_load_o;
  logic [CNT_W-1:0]         cnt_load_val_o;
  logic [CNT_W-1:0]         cnt_count_i;

  modport slave (
    input  req_i, req_val_i, cnt_count_i,
    output gnt_o, done_o, busy_o, owner_o, cnt_load_o, cnt_load_val_o
  );

  modport master (
    output req_i, req_val_i, cnt_count_i,
    input  gnt_o, done_o, busy_o, owner_o, cnt_load_o, cnt_load_val_o
  );
endinterface

// File: rtl/load_counter_sched.sv
// Shares one loadable up-counter between NUM_REQ requesters, one interval per grant.
// Define LCS_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority (index 0 highest).
//
// state  | meaning
// IDLE   | waiting for any req_i, arbitrates and grants
// LOAD   | counter is being loaded with the owner's start value
// RUN    | waiting for the counter to reach all-ones
// DONE   | done_o pulse to the owner, always returns to IDLE
module load_counter_sched #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 4
) (
  input logic                  clk,
  input logic                  reset,
  load_counter_sched_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [IDX_W-1:0] w_win;
  logic [CNT_W-1:0] w_val;

`ifdef LCS_ROUND_ROBIN_EN
  logic [IDX_W-1:0] r_last;
  logic             w_found;
  int               w_idx;

  // Search begins one past the last grant, wrapping at NUM_REQ.
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = int'(r_last) + 1 + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (!w_found && bus.req_i[IDX_W'(w_idx)]) begin
        w_win   = IDX_W'(w_idx);
        w_found = 1'b1;
      end
    end
  end
`else
  always_comb begin
    w_win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_i[IDX_W'(k)]) w_win = IDX_W'(k);
    end
  end
`endif

  always_comb begin
    w_val = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (IDX_W'(k) == w_win) w_val = bus.req_val_i[k*CNT_W +: CNT_W];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state            <= S_IDLE;
      bus.gnt_o          <= '0;
      bus.done_o         <= '0;
      bus.busy_o         <= 1'b0;
      bus.owner_o        <= '0;
      bus.cnt_load_o     <= 1'b0;
      bus.cnt_load_val_o <= '0;
`ifdef LCS_ROUND_ROBIN_EN
      r_last             <= IDX_W'(NUM_REQ - 1);
`endif
    end else begin
      bus.gnt_o      <= '0;
      bus.done_o     <= '0;
      bus.cnt_load_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|bus.req_i) begin
            r_state            <= S_LOAD;
            bus.gnt_o          <= NUM_REQ'(1) << w_win;
            bus.owner_o        <= w_win;
            bus.busy_o         <= 1'b1;
            bus.cnt_load_o     <= 1'b1;
            bus.cnt_load_val_o <= w_val;
`ifdef LCS_ROUND_ROBIN_EN
            r_last             <= w_win;
`endif
          end
        end
        S_LOAD: r_state <= S_RUN;
        S_RUN: begin
          // Only the first all-ones counts; the counter's wrap is never seen here.
          if (bus.cnt_count_i == {CNT_W{1'b1}}) begin
            r_state    <= S_DONE;
            bus.done_o <= NUM_REQ'(1) << bus.owner_o;
          end
        end
        S_DONE: begin
          r_state    <= S_IDLE;
          bus.busy_o <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          bus.busy_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_load_counter_sched.sv
// Directed bench for load_counter_sched with a behavioural counter and a grant/done scoreboard.
// Expected grant order follows LCS_ROUND_ROBIN_EN the same way the design does.
module tb_load_counter_sched;
  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  load_counter_sched_if #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) bus ();

  load_counter_sched #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running loadable counter; not reset so a dropped job leaves it running.
  logic [CNT_W-1:0] cnt_model = '0;
  always @(posedge clk) begin
    if (bus.cnt_load_o) cnt_model <= bus.cnt_load_val_o;
    else                cnt_model <= cnt_model + 1'b1;
  end
  assign bus.cnt_count_i = cnt_model;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [NUM_REQ-1:0] vec;
    int                 cyc;
    logic [CNT_W-1:0]   val;
    int                 idx;
  } ev_t;

  ev_t gq[$];
  ev_t dq[$];
  logic prev_gnt = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin : mon
    ev_t e;
    if (reset) begin
      prev_gnt <= 1'b0;
    end else begin
      if (prev_gnt) chk("load_drop", 32'(bus.cnt_load_o), 32'd0);
      prev_gnt <= |bus.gnt_o;
      if (bus.gnt_o != '0) begin
        chk("gnt_done_excl", 32'(bus.done_o), 32'd0);
        if (gq.size() == 0) chk("gnt_unexpected", 32'(bus.gnt_o), 32'd0);
        else begin
          e = gq.pop_front();
          chk("gnt_vec", 32'(bus.gnt_o), 32'(e.vec));
          chk("gnt_cyc", 32'(cyc), 32'(e.cyc));
          chk("gnt_load", 32'(bus.cnt_load_o), 32'd1);
          chk("gnt_load_val", 32'(bus.cnt_load_val_o), 32'(e.val));
          chk("gnt_owner", 32'(bus.owner_o), 32'(e.idx));
          chk("gnt_busy", 32'(bus.busy_o), 32'd1);
        end
      end
      if (bus.done_o != '0) begin
        if (dq.size() == 0) chk("done_unexpected", 32'(bus.done_o), 32'd0);
        else begin
          e = dq.pop_front();
          chk("done_vec", 32'(bus.done_o), 32'(e.vec));
          chk("done_cyc", 32'(cyc), 32'(e.cyc));
          chk("done_busy", 32'(bus.busy_o), 32'd1);
        end
      end
    end
  end

  task automatic job(input int k, input int v, input int gc, input bit with_done);
    ev_t e;
    e.vec = NUM_REQ'(1) << k;
    e.cyc = gc;
    e.val = CNT_W'(v);
    e.idx = k;
    gq.push_back(e);
    if (with_done) begin
      e.cyc = gc + 2 + ((1 << CNT_W) - 1 - v);
      dq.push_back(e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_val(input int k, input int v);
    bus.req_val_i[k*CNT_W +: CNT_W] = CNT_W'(v);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_gnt"},      32'(bus.gnt_o), 32'd0);
    chk({tag, "_done"},     32'(bus.done_o), 32'd0);
    chk({tag, "_busy"},     32'(bus.busy_o), 32'd0);
    chk({tag, "_owner"},    32'(bus.owner_o), 32'd0);
    chk({tag, "_load"},     32'(bus.cnt_load_o), 32'd0);
    chk({tag, "_load_val"}, 32'(bus.cnt_load_val_o), 32'd0);
  endtask

  initial begin
    int c;
    int k;
    bus.req_i     = '0;
    bus.req_val_i = '0;

    reset = 1'b1;
    tick(3);
    chk_idle_outputs("rst");
    reset = 1'b0;
    tick(1);

    // single job, start value 3
    c = cyc;
    set_val(0, 3);
    bus.req_i = 4'b0001;
    job(0, 3, c + 1, 1'b1);
    tick(1);
    bus.req_i = '0;
    tick(9);
    chk("single_busy_mid", 32'(bus.busy_o), 32'd1);
    tick(6);
    chk("single_busy_after", 32'(bus.busy_o), 32'd0);
    tick(1);

    // requester 2 at both extremes of the start value
    c = cyc;
    set_val(2, 15);
    bus.req_i = 4'b0100;
    job(2, 15, c + 1, 1'b1);
    tick(1);
    bus.req_i = '0;
    tick(4);

    c = cyc;
    set_val(2, 0);
    bus.req_i = 4'b0100;
    job(2, 0, c + 1, 1'b1);
    tick(1);
    bus.req_i = '0;
    tick(19);

    // simultaneous requests 0 and 2
    c = cyc;
    set_val(0, 12);
    set_val(2, 14);
    bus.req_i = 4'b0101;
    job(0, 12, c + 1, 1'b1);
    job(2, 14, c + 8, 1'b1);
    tick(1);
    bus.req_i = 4'b0100;
    tick(7);
    bus.req_i = '0;
    tick(5);

    // all four requesting continuously with all-ones start values
    c = cyc;
    for (int i = 0; i < NUM_REQ; i++) set_val(i, 15);
    bus.req_i = 4'b1111;
    for (int i = 0; i < 5; i++) begin
`ifdef LCS_ROUND_ROBIN_EN
      k = i % NUM_REQ;
`else
      k = 0;
`endif
      job(k, 15, c + 1 + 4 * i, 1'b1);
    end
    tick(17);
    bus.req_i = '0;
    tick(4);

    // asynchronous reset in the middle of a cycle
    c = cyc;
    set_val(0, 5);
    bus.req_i = 4'b0001;
    job(0, 5, c + 1, 1'b0);
    tick(1);
    bus.req_i = '0;
    tick(2);
    chk("async_busy_before", 32'(bus.busy_o), 32'd1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 chk_idle_outputs("async");
    tick(2);
    reset = 1'b0;
    tick(2);

    // reset during RUN, request still held through release
    c = cyc;
    set_val(1, 0);
    bus.req_i = 4'b0010;
    job(1, 0, c + 1, 1'b0);
    tick(6);
    reset = 1'b1;
    tick(2);
    chk("run_rst_done", 32'(bus.done_o), 32'd0);
    reset = 1'b0;
    job(1, 0, c + 9, 1'b1);
    tick(1);
    bus.req_i = '0;
    tick(18);

    chk("sb_gnt_empty", 32'(gq.size()), 32'd0);
    chk("sb_done_empty", 32'(dq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
